// File: rtl/demapping_i_if.sv
// demapping_i_if: sample-in / bit-and-word-out bundle between the RX front end, demapper and frame writer.
// Signals: demap_en, sample_in, sample_valid, sym_start (to demapper); bit_out, bit_valid, data_out,
//   data_valid, sync_err (from demapper); soft_out added when DEMAP_SOFT_OUT_EN is defined.
interface demapping_i_if #(
  parameter int WORD_W = 16
`ifdef DEMAP_SOFT_OUT_EN
  , parameter int ACC_W = 35
`endif
);
  logic demap_en;
  logic signed [15:0] sample_in;
  logic sample_valid;
  logic sym_start;
  logic bit_out;
  logic bit_valid;
  logic [WORD_W-1:0] data_out;
  logic data_valid;
  logic sync_err;
`ifdef DEMAP_SOFT_OUT_EN
  logic signed [ACC_W-1:0] soft_out;
  modport master (output demap_en, sample_in, sample_valid, sym_start,
                  input bit_out, bit_valid, data_out, data_valid, sync_err, soft_out);
  modport slave (input demap_en, sample_in, sample_valid, sym_start,
                 output bit_out, bit_valid, data_out, data_valid, sync_err, soft_out);
`else
  modport master (output demap_en, sample_in, sample_valid, sym_start,
                  input bit_out, bit_valid, data_out, data_valid, sync_err);
  modport slave (input demap_en, sample_in, sample_valid, sym_start,
                 output bit_out, bit_valid, data_out, data_valid, sync_err);
`endif
endinterface

// File: rtl/demapping_i.sv
// demapping_i: correlates SPB samples per symbol with a cos reference, decides each bit by sign, packs LSB-first words.
// Ports: clk, reset (sync, active-high); dm (demapping_i_if.slave) carries the sample input and bit/word/sync_err outputs.
// DEMAP_SOFT_OUT_EN: when defined, dm.soft_out presents the final correlation of each decided bit.
module demapping_i #(
  parameter int SPB = 8,
  parameter int ACC_W = 35,
  parameter int WORD_W = 16
) (
  input logic clk,
  input logic reset,
  demapping_i_if.slave dm
);
  localparam int SW = $clog2(SPB);
  localparam int BW = $clog2(WORD_W);
  localparam logic signed [15:0] COS_LUT [SPB] = '{16'sd16384, 16'sd11585, 16'sd0, -16'sd11585,
                                                  -16'sd16384, -16'sd11585, 16'sd0, 16'sd11585};
  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] smp_cnt_q, smp_cnt_d, idx;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum, prod_ext;
  logic signed [31:0] prod;
  logic [WORD_W-1:0] word_q, word_d, data_q, data_d;
  logic bit_q, bit_d, bv_q, bv_d, dv_q, dv_d, se_q, se_d;
  logic take, resync, last;
`ifdef DEMAP_SOFT_OUT_EN
  logic [ACC_W-1:0] soft_q, soft_d;
`endif
  // A sym_start sample is always index 0 and restarts the correlation from zero.
  assign idx = dm.sym_start ? '0 : smp_cnt_q;
  assign prod = $signed(dm.sample_in) * COS_LUT[idx];
  assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
  assign acc_sum = (dm.sym_start ? '0 : acc_q) + prod_ext;
  assign take = dm.sample_valid && (state_q != IDLE || dm.sym_start);
  assign resync = dm.sym_start && state_q == ACCUM && smp_cnt_q != '0;
  assign last = !dm.sym_start && smp_cnt_q == SW'(SPB-1);
  always_comb begin
    state_d = state_q;
    smp_cnt_d = smp_cnt_q;
    bit_cnt_d = bit_cnt_q;
    acc_d = acc_q;
    word_d = word_q;
    data_d = data_q;
    bit_d = bit_q;
    bv_d = 1'b0;
    dv_d = 1'b0;
    se_d = 1'b0;
`ifdef DEMAP_SOFT_OUT_EN
    soft_d = soft_q;
`endif
    if (take) begin
      state_d = ACCUM;
      acc_d = acc_sum;
      smp_cnt_d = dm.sym_start ? SW'(1) : smp_cnt_q + SW'(1);
      se_d = resync;
      if (last) begin
        state_d = DECIDE;
        acc_d = '0;
        smp_cnt_d = '0;
        bit_d = ~acc_sum[ACC_W-1];
        bv_d = 1'b1;
        word_d[bit_cnt_q] = bit_d;
        bit_cnt_d = bit_cnt_q + BW'(1);
        dv_d = bit_cnt_q == BW'(WORD_W-1);
        data_d = dv_d ? word_d : data_q;
`ifdef DEMAP_SOFT_OUT_EN
        soft_d = acc_sum;
`endif
      end
    end else if (state_q == DECIDE) begin
      state_d = ACCUM;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || !dm.demap_en) begin
      state_q <= IDLE;
      smp_cnt_q <= '0;
      bit_cnt_q <= '0;
      acc_q <= '0;
      word_q <= '0;
      data_q <= '0;
      bit_q <= 1'b0;
      bv_q <= 1'b0;
      dv_q <= 1'b0;
      se_q <= 1'b0;
`ifdef DEMAP_SOFT_OUT_EN
      soft_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      smp_cnt_q <= smp_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      acc_q <= acc_d;
      word_q <= word_d;
      data_q <= data_d;
      bit_q <= bit_d;
      bv_q <= bv_d;
      dv_q <= dv_d;
      se_q <= se_d;
`ifdef DEMAP_SOFT_OUT_EN
      soft_q <= soft_d;
`endif
    end
  end
  assign dm.bit_out = bit_q;
  assign dm.bit_valid = bv_q;
  assign dm.data_out = data_q;
  assign dm.data_valid = dv_q;
  assign dm.sync_err = se_q;
`ifdef DEMAP_SOFT_OUT_EN
  assign dm.soft_out = soft_q;
`endif
endmodule

// File: tb/tb_demapping_i.sv
// tb_demapping_i: randomized and directed stimulus for demapping_i checked every cycle against a queue-based correlation model.
module tb_demapping_i;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  demapping_i_if dm();
  demapping_i dut (.clk(clk), .reset(reset), .dm(dm));
  localparam int COS [8] = '{16384, 11585, 0, -11585, -16384, -11585, 0, 11585};
  int pass_cnt = 0;
  int total = 0;
  int bv_cnt = 0;
  logic cap_rst, cap_en, cap_v, cap_s;
  int cap_x;
  logic chk_on = 1'b0;
  int q[$];
  logic aligned;
  int bits_n;
  logic [15:0] word_acc;
  logic e_bv, e_bo, e_dv, e_se;
  logic [15:0] e_do;
  longint e_soft, last_acc;
  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
    total++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
  endtask
  always @(posedge clk) begin
    cap_rst <= reset;
    cap_en <= dm.demap_en;
    cap_v <= dm.sample_valid;
    cap_s <= dm.sym_start;
    cap_x <= int'(dm.sample_in);
  end
  always @(negedge clk) begin
    if (cap_rst === 1'b1) chk_on = 1'b1;
    if (chk_on) begin
      e_bv = 1'b0;
      e_dv = 1'b0;
      e_se = 1'b0;
      if (cap_rst || !cap_en) begin
        q.delete();
        aligned = 1'b0;
        bits_n = 0;
        word_acc = '0;
        e_bo = 1'b0;
        e_do = '0;
        e_soft = 0;
      end else if (cap_v && (cap_s || aligned)) begin
        if (cap_s) begin
          e_se = q.size() != 0;
          q.delete();
          aligned = 1'b1;
        end
        q.push_back(cap_x);
        if (q.size() == 8) begin
          last_acc = 0;
          foreach (q[i]) last_acc += longint'(q[i]) * COS[i];
          e_bo = last_acc >= 0;
          e_bv = 1'b1;
          e_soft = last_acc;
          word_acc[bits_n] = e_bo;
          bits_n++;
          if (bits_n == 16) begin
            e_do = word_acc;
            e_dv = 1'b1;
            bits_n = 0;
          end
          q.delete();
        end
      end
      chk("bit_valid", dm.bit_valid, e_bv);
      chk("bit_out", dm.bit_out, e_bo);
      chk("data_valid", dm.data_valid, e_dv);
      chk("data_out", dm.data_out, e_do);
      chk("sync_err", dm.sync_err, e_se);
`ifdef DEMAP_SOFT_OUT_EN
      chk("soft_out", dm.soft_out, e_soft);
`endif
      if (dm.bit_valid === 1'b1) bv_cnt++;
    end
  end
  task automatic drive(input logic v, input logic s, input int x);
    @(negedge clk);
    dm.sample_valid = v;
    dm.sym_start = s;
    dm.sample_in = 16'(x);
  endtask
  task automatic send_sym(input logic b, input logic st, input int n, input int gap, input int noise);
    int nz;
    for (int k = 0; k < n; k++) begin
      while (gap > 0 && $urandom_range(0, 99) < gap) drive(0, 0, 0);
      nz = noise > 0 ? int'($urandom_range(0, 2 * noise)) - noise : 0;
      drive(1'b1, st && k == 0, (b ? COS[k] : -COS[k]) + nz);
    end
  endtask
  task automatic send_word(input logic [15:0] w, input logic st, input int gap, input int noise);
    for (int i = 0; i < 16; i++) send_sym(w[i], st && i == 0, 8, gap, noise);
  endtask
  task automatic restart();
    drive(0, 0, 0);
    dm.demap_en = 1'b0;
    drive(0, 0, 0);
    dm.demap_en = 1'b1;
  endtask
  initial begin
    int r;
    int bvc;
    logic [15:0] w;
    reset = 1'b1;
    dm.demap_en = 1'b0;
    dm.sample_valid = 1'b0;
    dm.sym_start = 1'b0;
    dm.sample_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_bit_valid", dm.bit_valid, 0);
    chk("rst_data_out", dm.data_out, 0);
    chk("rst_sync_err", dm.sync_err, 0);
    reset = 1'b0;
    dm.demap_en = 1'b1;
    send_sym(1, 1, 8, 0, 0);
    drive(0, 0, 0);
    chk("one_bit_valid", dm.bit_valid, 1);
    chk("one_bit_out", dm.bit_out, 1);
`ifdef DEMAP_SOFT_OUT_EN
    chk("one_soft_out", dm.soft_out, longint'(2) * 16384 * 16384 + longint'(4) * 11585 * 11585);
`endif
    drive(0, 0, 0);
    chk("one_model_acc", last_acc, longint'(2) * 16384 * 16384 + longint'(4) * 11585 * 11585);
    restart();
    send_word(16'hA5C3, 1, 0, 0);
    drive(0, 0, 0);
    chk("word_data_valid", dm.data_valid, 1);
    chk("word_bit_valid", dm.bit_valid, 1);
    chk("word_data_out", dm.data_out, 16'hA5C3);
    drive(0, 0, 0);
    chk("word_model", e_do, 16'hA5C3);
    restart();
    send_word(16'hA5C3, 1, 30, 1000);
    drive(0, 0, 0);
    chk("gap_data_valid", dm.data_valid, 1);
    chk("gap_data_out", dm.data_out, 16'hA5C3);
    restart();
    w = 16'hABCD;
    for (int i = 0; i < 3; i++) send_sym(w[i], i == 0, 8, 0, 0);
    send_sym(0, 0, 5, 0, 0);
    drive(1, 1, COS[0]);
    drive(1, 0, COS[1]);
    chk("resync_sync_err", dm.sync_err, 1);
    for (int k = 2; k < 8; k++) drive(1, 0, COS[k]);
    drive(0, 0, 0);
    chk("resync_bit_valid", dm.bit_valid, 1);
    chk("resync_bit_out", dm.bit_out, 1);
    for (int i = 4; i < 16; i++) send_sym(w[i], 0, 8, 0, 0);
    drive(0, 0, 0);
    chk("resync_data_valid", dm.data_valid, 1);
    chk("resync_data_out", dm.data_out, 16'hABCD);
    restart();
    drive(1, 1, 0);
    repeat (7) drive(1, 0, 0);
    drive(0, 0, 0);
    chk("tie_bit_valid", dm.bit_valid, 1);
    chk("tie_bit_out", dm.bit_out, 1);
    for (int i = 0; i < 5; i++) send_sym($urandom_range(0, 1), 0, 8, 0, 0);
    send_sym(1, 0, 3, 0, 0);
    dm.demap_en = 1'b0;
    drive(0, 0, 0);
    dm.demap_en = 1'b1;
    send_word(16'h1234, 1, 10, 500);
    drive(0, 0, 0);
    chk("dis_data_valid", dm.data_valid, 1);
    chk("dis_data_out", dm.data_out, 16'h1234);
    send_sym(1, 0, 4, 0, 0);
    reset = 1'b1;
    repeat (3) drive(0, 0, 0);
    chk("rst2_data_out", dm.data_out, 0);
    chk("rst2_bit_out", dm.bit_out, 0);
    reset = 1'b0;
    bvc = bv_cnt;
    send_sym(1, 0, 8, 0, 0);
    repeat (2) drive(0, 0, 0);
    chk("rst2_needs_start", bv_cnt, bvc);
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        dm.demap_en = 1'b0;
        drive(0, 0, 0);
        dm.demap_en = 1'b1;
      end
      send_sym($urandom_range(0, 1), r < 15, (r >= 15 && r < 22) ? int'($urandom_range(1, 7)) : 8, 20, 9000);
    end
    repeat (3) drive(0, 0, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
